// File: rtl/board_memory.sv
`default_nettype none
// ============================================================================
// Module   : board_memory
// Brief    : Authoritative 8x8 chess board with capture, half-move, promotion
//            and king-capture game-over tracking.
// Revision : 1.0 - initial release
// ============================================================================
module board_memory (
  input  logic         clk,
  input  logic         rst,
  input  logic         new_game,
  input  logic         wr_en,
  input  logic [5:0]   wr_addr,
  input  logic [3:0]   wr_piece,
  input  logic [5:0]   rd_addr,
  output logic [3:0]   rd_piece,
  output logic [255:0] board,
  output logic [4:0]   captured_white,
  output logic [4:0]   captured_black,
  output logic [7:0]   half_moves,
  output logic         game_over,
  output logic         winner
);

  localparam logic [2:0] C_EMPTY  = 3'd0;
  localparam logic [2:0] C_PAWN   = 3'd1;
  localparam logic [2:0] C_BISHOP = 3'd2;
  localparam logic [2:0] C_KNIGHT = 3'd3;
  localparam logic [2:0] C_ROOK   = 3'd4;
  localparam logic [2:0] C_QUEEN  = 3'd5;
  localparam logic [2:0] C_KING   = 3'd6;
  localparam logic       C_WHITE  = 1'b0;
  localparam logic       C_BLACK  = 1'b1;
  localparam logic [4:0] C_CAP_MAX = 5'd16;

  function automatic logic [255:0] init_board();
    logic [255:0] b;
    logic [2:0]   back;
    b = '0;
    for (int col = 0; col < 8; col++) begin
      case (col)
        0, 7:    back = C_ROOK;
        1, 6:    back = C_KNIGHT;
        2, 5:    back = C_BISHOP;
        3:       back = C_QUEEN;
        default: back = C_KING;
      endcase
      b[4*col      +: 4] = {C_BLACK, back};
      b[4*(8+col)  +: 4] = {C_BLACK, C_PAWN};
      b[4*(48+col) +: 4] = {C_WHITE, C_PAWN};
      b[4*(56+col) +: 4] = {C_WHITE, back};
    end
    return b;
  endfunction

  localparam logic [255:0] C_INIT_BOARD = init_board();

  logic [255:0] r_board;
  logic [4:0]   r_cap_white;
  logic [4:0]   r_cap_black;
  logic [7:0]   r_half_moves;
  logic         r_game_over;
  logic         r_winner;

  logic         w_accept;
  logic [3:0]   w_old;
  logic [3:0]   w_store;
  logic         w_nonempty;
  logic         w_capture;

  assign w_accept   = wr_en & ~new_game & ~r_game_over;
  assign w_old      = r_board[{wr_addr, 2'b00} +: 4];
  assign w_nonempty = (wr_piece[2:0] != C_EMPTY);
  assign w_capture  = w_nonempty && (w_old[2:0] != C_EMPTY) && (w_old[3] != wr_piece[3]);

  // Pawns reaching the far rank are stored as a queen of the same colour.
  always_comb begin
    w_store = wr_piece;
    if (wr_piece == {C_WHITE, C_PAWN} && wr_addr[5:3] == 3'd0)
      w_store = {C_WHITE, C_QUEEN};
    else if (wr_piece == {C_BLACK, C_PAWN} && wr_addr[5:3] == 3'd7)
      w_store = {C_BLACK, C_QUEEN};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_board      <= C_INIT_BOARD;
      r_cap_white  <= '0;
      r_cap_black  <= '0;
      r_half_moves <= '0;
      r_game_over  <= 1'b0;
      r_winner     <= 1'b0;
    end else if (new_game) begin
      r_board      <= C_INIT_BOARD;
      r_cap_white  <= '0;
      r_cap_black  <= '0;
      r_half_moves <= '0;
      r_game_over  <= 1'b0;
      r_winner     <= 1'b0;
    end else if (w_accept) begin
      r_board[{wr_addr, 2'b00} +: 4] <= w_store;
      // Erase writes (EMPTY) only clear the source square.
      if (w_nonempty) begin
        r_half_moves <= r_half_moves + 8'd1;
        if (w_capture) begin
          if (w_old[3] == C_WHITE) begin
            if (r_cap_white != C_CAP_MAX)
              r_cap_white <= r_cap_white + 5'd1;
          end else begin
            if (r_cap_black != C_CAP_MAX)
              r_cap_black <= r_cap_black + 5'd1;
          end
          if (w_old[2:0] == C_KING) begin
            r_game_over <= 1'b1;
            r_winner    <= wr_piece[3];
          end
        end
      end
    end
  end

  assign rd_piece       = r_board[{rd_addr, 2'b00} +: 4];
  assign board          = r_board;
  assign captured_white = r_cap_white;
  assign captured_black = r_cap_black;
  assign half_moves     = r_half_moves;
  assign game_over      = r_game_over;
  assign winner         = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_board_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_memory
// Brief    : Directed, table-driven self-checking bench for board_memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_memory;

  logic         clk;
  logic         rst;
  logic         new_game;
  logic         wr_en;
  logic [5:0]   wr_addr;
  logic [3:0]   wr_piece;
  logic [5:0]   rd_addr;
  logic [3:0]   rd_piece;
  logic [255:0] board;
  logic [4:0]   captured_white;
  logic [4:0]   captured_black;
  logic [7:0]   half_moves;
  logic         game_over;
  logic         winner;

  int n_tests;
  int n_fail;

  board_memory dut (
    .clk            (clk),
    .rst            (rst),
    .new_game       (new_game),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_piece       (wr_piece),
    .rd_addr        (rd_addr),
    .rd_piece       (rd_piece),
    .board          (board),
    .captured_white (captured_white),
    .captured_black (captured_black),
    .half_moves     (half_moves),
    .game_over      (game_over),
    .winner         (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ng;
    logic       we;
    logic [5:0] addr;
    logic [3:0] piece;
    logic [5:0] raddr;
    logic [3:0] exp_rd;
    logic [4:0] exp_cw;
    logic [4:0] exp_cb;
    logic [7:0] exp_hm;
    logic       exp_go;
    logic       exp_win;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; return 1ns after the rising edge.
  task automatic step(input logic ng, input logic we, input logic [5:0] a,
                      input logic [3:0] p, input logic [5:0] ra);
    @(negedge clk);
    new_game = ng;
    wr_en    = we;
    wr_addr  = a;
    wr_piece = p;
    rd_addr  = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic [4:0] cw, input logic [4:0] cb,
                            input logic [7:0] hm, input logic go, input logic win);
    chk({tag, " captured_white"}, 32'(captured_white), 32'(cw));
    chk({tag, " captured_black"}, 32'(captured_black), 32'(cb));
    chk({tag, " half_moves"},     32'(half_moves),     32'(hm));
    chk({tag, " game_over"},      32'(game_over),      32'(go));
    if (go) chk({tag, " winner"}, 32'(winner), 32'(win));
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    new_game = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_piece = '0;
    rd_addr  = 6'd4;

    //            ng   we   addr   piece    raddr  rd       cw  cb  hm  go  win
    vecs[0]  = '{1'b0,1'b1,6'd36,4'b0001,6'd36,4'b0001, 5'd0,5'd0,8'd1,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b1,6'd52,4'b0000,6'd52,4'b0000, 5'd0,5'd0,8'd1,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b1,6'd12,4'b0101,6'd12,4'b0101, 5'd0,5'd1,8'd2,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b1,6'd3, 4'b0001,6'd3, 4'b0101, 5'd0,5'd2,8'd3,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,6'd20,4'b1001,6'd20,4'b1001, 5'd0,5'd2,8'd4,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,6'd48,4'b1011,6'd48,4'b1011, 5'd1,5'd2,8'd5,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,6'd12,4'b0000,6'd12,4'b0000, 5'd1,5'd2,8'd5,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,6'd0, 4'b0101,6'd0, 4'b1100, 5'd1,5'd2,8'd5,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,6'd1, 4'b1101,6'd1, 4'b1101, 5'd1,5'd2,8'd6,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b1,6'd40,4'b0011,6'd40,4'b0000, 5'd0,5'd0,8'd0,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b1,6'd59,4'b1001,6'd59,4'b1101, 5'd1,5'd0,8'd1,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b1,6'd60,4'b1100,6'd60,4'b1100, 5'd2,5'd0,8'd2,1'b1,1'b1};
    vecs[12] = '{1'b0,1'b1,6'd0, 4'b0101,6'd0, 4'b1100, 5'd2,5'd0,8'd2,1'b1,1'b1};
    vecs[13] = '{1'b0,1'b1,6'd8, 4'b0000,6'd8, 4'b1001, 5'd2,5'd0,8'd2,1'b1,1'b1};
    vecs[14] = '{1'b1,1'b0,6'd0, 4'b0000,6'd60,4'b0110, 5'd0,5'd0,8'd0,1'b0,1'b0};
    vecs[15] = '{1'b0,1'b1,6'd4, 4'b0100,6'd4, 4'b0100, 5'd0,5'd1,8'd1,1'b1,1'b0};
    vecs[16] = '{1'b1,1'b0,6'd0, 4'b0000,6'd59,4'b0101, 5'd0,5'd0,8'd0,1'b0,1'b0};

    // Reset state
    #12;
    chk("reset sq0",  32'(board[3:0]),     32'hC);
    chk("reset sq60", 32'(board[243:240]), 32'h6);
    chk("reset sq32", 32'(board[131:128]), 32'h0);
    chk("reset sq15", 32'(board[63:60]),   32'h9);
    chk("reset sq49", 32'(board[199:196]), 32'h1);
    chk("reset rd4",  32'(rd_piece),       32'hE);
    chk_status("reset", 5'd0, 5'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].ng, vecs[i].we, vecs[i].addr, vecs[i].piece, vecs[i].raddr);
      chk($sformatf("vec%0d rd_piece", i), 32'(rd_piece), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d board", i), 32'(board[4*vecs[i].raddr +: 4]), 32'(vecs[i].exp_rd));
      chk_status($sformatf("vec%0d", i), vecs[i].exp_cw, vecs[i].exp_cb,
                 vecs[i].exp_hm, vecs[i].exp_go, vecs[i].exp_win);
    end

    // Read of the square being written shows the old value until the edge
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 6'd36; wr_piece = 4'b0001; rd_addr = 6'd36; new_game = 1'b0;
    #1;
    chk("rdw before edge", 32'(rd_piece), 32'h0);
    @(posedge clk);
    #1;
    chk("rdw after edge", 32'(rd_piece), 32'h1);

    // Capture counter saturation: 18 white pieces lost on square 32
    step(1'b1, 1'b0, 6'd0, 4'h0, 6'd32);
    for (int k = 0; k < 18; k++) begin
      step(1'b0, 1'b1, 6'd32, 4'b0001, 6'd32);
      step(1'b0, 1'b1, 6'd32, 4'b1001, 6'd32);
      step(1'b0, 1'b1, 6'd32, 4'b0000, 6'd32);
    end
    chk_status("saturate", 5'd16, 5'd0, 8'd36, 1'b0, 1'b0);

    // half_moves wraps at 256 (same-colour overwrites, no captures)
    step(1'b1, 1'b0, 6'd0, 4'h0, 6'd33);
    for (int k = 0; k < 256; k++) step(1'b0, 1'b1, 6'd33, 4'b0001, 6'd33);
    chk_status("wrap", 5'd0, 5'd0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 6'd33, 4'b0001, 6'd33);
    chk("wrap+1 half_moves", 32'(half_moves), 32'd1);

    // Asynchronous reset mid-game, away from any clock edge
    @(negedge clk);
    wr_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst half_moves", 32'(half_moves), 32'd0);
    chk("async rst sq33", 32'(board[135:132]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 6'd44, 4'b0001, 6'd44);
    chk("post-rst write", 32'(rd_piece), 32'h1);
    chk("post-rst half_moves", 32'(half_moves), 32'd1);

    step(1'b0, 1'b0, 6'd0, 4'h0, 6'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
